// File: rtl/mult_nib_seq.sv
// mult_nib_seq: unsigned AW x AW multiplier built from one shared 4x4 nibble
// multiplier, one partial product per clock, accumulated into a 2*AW register.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid_i     operand pair valid          in_ready_o  accepts operands (IDLE only)
//   a_i, b_i       unsigned operands, AW bits
//   out_valid_o    p_o holds a finished product out_ready_i consumer accepts p_o
//   p_o            unsigned product, 2*AW bits busy_o      high in CALC or DONE
//
// Optional feature (macro MULT_NIB_SEQ_ZERO_SKIP_EN): a zero operand at the input
// handshake skips the nibble walk, giving out_valid one cycle after the handshake
// with p = 0.

module mult_nib_seq #(
    parameter int unsigned N_NIB = 2,
    parameter int unsigned IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [4*N_NIB-1:0]   a_i,
    input  logic [4*N_NIB-1:0]   b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [8*N_NIB-1:0]   p_o,
    output logic                 busy_o
);

    localparam int unsigned AW = 4 * N_NIB;
    localparam int unsigned PW = 8 * N_NIB;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_NIB - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    a_q, a_d;
    logic [AW-1:0]    b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    p_q, p_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;

    // Shared nibble multiplier and its shifted partial product.
    logic [AW-1:0]    a_sh, b_sh;
    logic [3:0]       a_nib, b_nib;
    logic [7:0]       pp;
    logic [IDX_W:0]   ij_sum;
    logic [PW-1:0]    pp_sh;
    logic [PW-1:0]    acc_sum;

    always_comb begin
        a_sh    = a_q >> {i_q, 2'b00};
        b_sh    = b_q >> {j_q, 2'b00};
        a_nib   = a_sh[3:0];
        b_nib   = b_sh[3:0];
        pp      = {4'b0000, a_nib} * {4'b0000, b_nib};
        ij_sum  = {1'b0, i_q} + {1'b0, j_q};
        pp_sh   = PW'(pp) << {ij_sum, 2'b00};
        acc_sum = acc_q + pp_sh;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        i_d     = i_q;
        j_d     = j_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StCalc;
`ifdef MULT_NIB_SEQ_ZERO_SKIP_EN
                    // Jump straight to the final index pair: its partial product is
                    // zero, so one CALC edge lands in DONE with p = 0.
                    if (a_i == '0 || b_i == '0) begin
                        i_d = LastIdx;
                        j_d = LastIdx;
                    end
`endif
                end
            end
            StCalc: begin
                acc_d = acc_sum;
                if (j_q == LastIdx) begin
                    j_d = '0;
                    if (i_q == LastIdx) begin
                        i_d     = '0;
                        p_d     = acc_sum;
                        state_d = StDone;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = (state_q == StDone);
    assign p_o         = p_q;

endmodule

// File: tb/tb_mult_nib_seq.sv
// Directed bench for mult_nib_seq at the default N_NIB = 2.
module tb_mult_nib_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int errors;
    int checks;
    time hs_time;
    time prev_hs;

    mult_nib_seq #(.N_NIB(2), .IDX_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .p_o         (p),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE, ends at the negedge after the output handshake.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [15:0] exp_p, input int exp_lat,
                          input int stall, input bit poke);
        int lat;
        int low;
        lat = 0;
        low = 0;
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        a         = op_a;
        b         = op_b;
        @(posedge clk);
        hs_time = $time;
        #1;
        in_valid = 1'b0;
        a        = 8'hxx;
        b        = 8'hxx;
        while (lat < 40) begin
            @(negedge clk);
            if (!in_ready) low++;
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("product", p, exp_p);
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                in_valid = 1'b1;
                a        = 8'h55;
                b        = 8'h01;
            end
            @(posedge clk);
            @(negedge clk);
            low++;
            check("stall_valid", out_valid, 1);
            check("stall_p", p, exp_p);
            check("stall_busy", busy, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_low_cycles", low, exp_lat + 1 + stall);
        check("valid_drop", out_valid, 0);
        check("idle_ready", in_ready, 1);
        check("p_kept", p, exp_p);
    endtask

    initial begin
        int zl;
        logic [7:0] ra, rb;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_p", p, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", in_ready, 1);

        run_op(8'h0F, 8'h0F, 16'h00E1, 4, 0, 1'b0);

        run_op(8'hFF, 8'hFF, 16'hFE01, 4, 0, 1'b0);
        prev_hs = hs_time;
        run_op(8'hA5, 8'h3C, 16'h26AC, 4, 0, 1'b0);
        check("b2b_spacing", 32'(hs_time - prev_hs), 60);

        // Stalled output with a competing operand offered during DONE.
        run_op(8'h12, 8'h34, 16'h03A8, 4, 3, 1'b1);
        @(negedge clk);
        check("poke_ignored", busy, 0);

        // Abort during the second CALC cycle.
        in_valid = 1'b1;
        a        = 8'h77;
        b        = 8'h88;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_p", p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
        check("abort_ready", in_ready, 1);
        run_op(8'h02, 8'h03, 16'h0006, 4, 0, 1'b0);

`ifdef MULT_NIB_SEQ_ZERO_SKIP_EN
        zl = 1;
`else
        zl = 4;
`endif
        run_op(8'h00, 8'hC3, 16'h0000, zl, 0, 1'b0);
        run_op(8'h9A, 8'h00, 16'h0000, zl, 1, 1'b0);

        // Short random sweep with stalls, checked against a*b.
        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom_range(1, 255));
            rb = 8'($urandom_range(1, 255));
            run_op(ra, rb, 16'(ra) * 16'(rb), 4, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
